// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: operation encoding derived from
// {push, pop} and the pointer-width helper used by the stack and its storage.
package stack_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Address bits needed to index DEPTH slots; never below 1 so ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DATA_W x DEPTH stack storage: one synchronous write port, one asynchronous
// read port. Define LIFO_CLEAR_ON_POP_EN to add a clear-all port zeroing every slot.
module stack_regfile
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
`ifdef LIFO_CLEAR_ON_POP_EN
  input  logic              clr_all_i,
`endif
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef LIFO_CLEAR_ON_POP_EN
  always_ff @(posedge clk) begin
    if (clr_all_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  // No reset on the array so it can map onto inferred RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack: pointer, operation decode and sticky error flags
// around stack_regfile. LIFO_CLEAR_ON_POP_EN zeroes popped slots and all slots on rst.
module param_lifo_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   SP_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ADR_ONE = PTR_W'(1);

  logic [PTR_W:0]    sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [1:0]        op;
  logic              is_empty, is_full;
  logic [PTR_W-1:0]  top_addr;
  logic [DATA_W-1:0] rd_data;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  assign op       = {push, pop};
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == DEPTH_C);
  // SP is the next free slot, so the live top sits one below it.
  assign top_addr = sp_q[PTR_W-1:0] - ADR_ONE;

  // Operations are evaluated only when en=1; a rejected half of an operation
  // raises its sticky flag, and a fresh error in the same cycle beats err_clr.
  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    we     = 1'b0;
    waddr  = sp_q[PTR_W-1:0];
    wdata  = din;
    if (en) begin
      if (err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we   = 1'b1;
            sp_d = sp_q + SP_ONE;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d = rd_data;
            sp_d   = sp_q - SP_ONE;
`ifdef LIFO_CLEAR_ON_POP_EN
            we     = 1'b1;
            waddr  = top_addr;
            wdata  = '0;
`endif
          end
        end
        OP_REPL: begin
          if (is_empty) begin
            we    = 1'b1;
            sp_d  = SP_ONE;
            unf_d = 1'b1;
          end else begin
            dout_d = rd_data;
            we     = 1'b1;
            waddr  = top_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clk       (clk),
`ifdef LIFO_CLEAR_ON_POP_EN
    .clr_all_i (rst),
`endif
    .we_i      (we & ~rst),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_i   (top_addr),
    .rdata_o   (rd_data)
  );

  assign dout      = dout_q;
  assign top       = is_empty ? '0 : rd_data;
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/param_lifo_stack.md
Name: param_lifo_stack

Overview:
- Parametrised LIFO stack for the datapath: generic data width and depth.
- Supports single-cycle push, pop and combined push+pop (replace top).
- Provides a live top-of-stack peek, an occupancy count, and sticky overflow/underflow error flags.
- Serves as the next-generation stack for the CPU's call/return and operand storage.

Parameters:
- DATA_W, 16, data word width in bits.
- DEPTH, 32, number of slots; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), stack pointer width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  cycle enable; when low, push/pop/err_clr are ignored.
- push  in  1  write din onto the stack.
- pop  in  1  remove the top entry into dout.
- din  in  DATA_W  data to push.
- err_clr  in  1  clears the sticky error flags.
- dout  out  DATA_W  registered; last popped value.
- top  out  DATA_W  combinational; mem[SP-1], or 0 when empty.
- count  out  PTR_W+1  number of occupied slots, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a push was rejected.
- underflow  out  1  sticky; a pop was rejected.

Behaviour:
- Reset:
  - rst has priority over everything, including en low.
  - Next edge: SP=0, dout=0, overflow=0, underflow=0.
  - Hence count=0, empty=1, full=0, top=0.
  - Reset mid-operation discards any concurrent push/pop.
- SP: internal, PTR_W+1 bits, points to the next free slot. count equals SP.
- Gating: en=0 holds all state (memory, SP, dout, flags).
- With en=1 and no rst, operations are evaluated on each rising edge:
  - push only, not full: mem[SP]<=din; SP<=SP+1.
  - push only, full: no write; SP unchanged; overflow<=1.
  - pop only, not empty: dout<=mem[SP-1]; SP<=SP-1.
  - pop only, empty: dout unchanged; underflow<=1.
  - push+pop, not empty (full included): dout<=mem[SP-1]; mem[SP-1]<=din; SP unchanged. This is a replace-top; no error.
  - push+pop, empty: push performed (mem[0]<=din, SP<=1); pop rejected; underflow<=1; dout unchanged.
  - Neither: hold.
- Latency:
  - dout is valid the cycle after the pop edge.
  - top/count/empty/full reflect the updated SP immediately after the edge.
- err_clr=1 clears both flags. If a new error occurs in the same cycle, set wins.
- Flags are sticky until err_clr or rst; they do not block further operations.
- Pointer never wraps: SP saturates in 0..DEPTH via the full/empty guards.

Optional Feature:
- Macro: LIFO_CLEAR_ON_POP_EN.
- Defined:
  - A popped slot is written to 0 (skipped on replace-top).
  - rst zeroes all DEPTH slots.
  - Bench can check that mem is all-zero after drain.
- Undefined:
  - Memory contents are never cleared; stale data remains in freed slots.
  - Memory has no reset, so it can map to inferred RAM.
  - Externally visible outputs are identical in both builds, since top reads 0 when empty regardless.

Decomposition:
- Package stack_pkg:
  - Op encoding constants OP_NONE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11, derived from {push,pop}.
  - Function for pointer width.
- Sub-module stack_regfile:
  - DATA_W x DEPTH storage, one write port, asynchronous read port.
  - Optional clear-all under the macro.
- param_lifo_stack holds the pointer, control and flag logic.

Test Plan:
- Reset then idle: rst=1 for one edge, with en=0 -> count=0, empty=1, full=0, dout=0, top=0, flags=0.
- Fill (DEPTH=4): push 0x1111, 0x2222, 0x3333, 0x4444.
  - -> full=1, count=4, top=0x4444.
  - Fifth push 0xDEAD -> overflow=1, count=4, top=0x4444.
- Drain: pop x4 -> dout sequence 0x4444, 0x3333, 0x2222, 0x1111; empty=1 after the 4th pop.
  - Fifth pop -> underflow=1, dout stays 0x1111.
- Replace-top: stack [0xAAAA, 0xBBBB], push+pop din=0xCCCC -> dout=0xBBBB, top=0xCCCC, count=2, no flags.
  - Same operation when full -> no overflow.
- Empty push+pop: din=0x5555 -> count=1, top=0x5555, underflow=1, dout unchanged.
  - Then err_clr=1 with push -> flags=0.
- Enable and reset priority:
  - en=0 with push=1 for 3 cycles -> no change.
  - rst mid-fill at count=3 with push=1 -> count=0.
  - With LIFO_CLEAR_ON_POP_EN defined, all slots read 0.
